pwm_modulator: RTL and testbench

Consumer end of the channel level interface: takes a 9-bit compare level from a tone channel (pulse/saw/sine generator) and converts it into a single-bit PWM pin drive. It is a free-running period counter with double-buffered compare and top registers, so new levels and periods apply only at period boundaries (glitch-free). A one-cycle period-start strobe lets upstream sequencers/mixers pace their updates.

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_shadow_reg.sv | 46 ++++
 rtl/pwm_modulator.sv | 91 +++++++++
 tb/tb_pwm_modulator.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// ============================================================================
// Module  : pwm_pkg
// Purpose : Shared widths and defaults for the tone channel -> PWM path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  localparam int unsigned c_PWM_WIDTH       = 9;
  localparam int unsigned c_PWM_TOP_DEFAULT = 255;
  localparam int unsigned c_PWM_CNT_WIDTH   = c_PWM_WIDTH;

endpackage : pwm_pkg

`default_nettype wire

// File: rtl/pwm_shadow_reg.sv
// ============================================================================
// Module  : pwm_shadow_reg
// Purpose : Double-buffered value register; shadow capture plus load into the
//           active copy, with same-cycle bypass of a fresh write.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_shadow_reg
  import pwm_pkg::*;
#(
  parameter int unsigned          WIDTH       = c_PWM_WIDTH,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_valid,
  input  logic             i_load,
  output logic [WIDTH-1:0] o_active
);

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_active;
  logic [WIDTH-1:0] w_next_shadow;

  // A write landing on the load cycle must win over the stale shadow.
  assign w_next_shadow = i_valid ? i_value : r_shadow;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= RESET_VALUE;
      r_active <= RESET_VALUE;
    end else begin
      r_shadow <= w_next_shadow;
      if (i_load) begin
        r_active <= w_next_shadow;
      end
    end
  end

  assign o_active = r_active;

endmodule : pwm_shadow_reg

`default_nettype wire

// File: rtl/pwm_modulator.sv
// ============================================================================
// Module  : pwm_modulator
// Purpose : Free-running PWM period counter with glitch-free, period-aligned
//           compare/top updates and a period-start strobe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_modulator
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH       = c_PWM_WIDTH,
  parameter int unsigned TOP_DEFAULT = c_PWM_TOP_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_compare,
  input  logic             i_compare_valid,
  input  logic [WIDTH-1:0] i_top,
  input  logic             i_top_valid,
  output logic             o_pwm,
  output logic             o_period_start,
  output logic [WIDTH-1:0] o_compare_active
);

  logic [WIDTH-1:0] r_count;
  logic             r_pwm;
  logic             r_period_start;
  logic [WIDTH-1:0] w_active_cmp;
  logic [WIDTH-1:0] w_active_top;
  logic             w_at_top;
  logic             w_load;

  assign w_at_top = (r_count == w_active_top);

  // While disabled the active copies keep following the shadows, so the
  // first enabled period already runs with every pending value.
  assign w_load = !i_enable || w_at_top;

  pwm_shadow_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE ('0)
  ) u_cmp_shadow (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_value  (i_compare),
    .i_valid  (i_compare_valid),
    .i_load   (w_load),
    .o_active (w_active_cmp)
  );

  pwm_shadow_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (WIDTH'(TOP_DEFAULT))
  ) u_top_shadow (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_value  (i_top),
    .i_valid  (i_top_valid),
    .i_load   (w_load),
    .o_active (w_active_top)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (w_load) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_pwm          <= i_enable && (r_count < w_active_cmp);
      r_period_start <= i_enable && (r_count == '0);
    end
  end

  assign o_pwm            = r_pwm;
  assign o_period_start   = r_period_start;
  assign o_compare_active = w_active_cmp;

endmodule : pwm_modulator

`default_nettype wire

// File: tb/tb_pwm_modulator.sv
// ============================================================================
// Module  : tb_pwm_modulator
// Purpose : Directed and randomized checks of pwm_modulator against a
//           period-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_modulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [8:0] cmp;
  logic       cmp_vld;
  logic [8:0] top;
  logic       top_vld;
  logic       pwm;
  logic       ps;
  logic [8:0] cmp_act;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: position inside the current period and the values in force.
  int m_pos, m_cmp, m_top, m_sh_cmp, m_sh_top;
  int exp_pwm, exp_ps;

  always #5 clk = ~clk;

  pwm_modulator dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_enable         (en),
    .i_compare        (cmp),
    .i_compare_valid  (cmp_vld),
    .i_top            (top),
    .i_top_valid      (top_vld),
    .o_pwm            (pwm),
    .o_period_start   (ps),
    .o_compare_active (cmp_act)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_cmp = 0; m_top = 255; m_sh_cmp = 0; m_sh_top = 255;
    exp_pwm = 0; exp_ps = 0;
  endtask

  // One clock edge of the reference: outputs describe the period position
  // just finished; new values take effect only at a period boundary or
  // while the modulator is idle.
  task automatic model_edge();
    int new_cmp, new_top;
    if (!rst_n) begin
      model_reset();
      return;
    end
    exp_pwm = (en && (m_pos < m_cmp)) ? 1 : 0;
    exp_ps  = (en && (m_pos == 0)) ? 1 : 0;
    new_cmp = cmp_vld ? int'(cmp) : m_sh_cmp;
    new_top = top_vld ? int'(top) : m_sh_top;
    if (!en || m_pos == m_top) begin
      m_pos = 0;
      m_cmp = new_cmp;
      m_top = new_top;
    end else begin
      m_pos = m_pos + 1;
    end
    m_sh_cmp = new_cmp;
    m_sh_top = new_top;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("pwm", pwm, exp_pwm);
    chk("period_start", ps, exp_ps);
    chk("compare_active", cmp_act, m_cmp);
    cmp_vld = 1'b0;
    top_vld = 1'b0;
  endtask

  task automatic run_until_pos(input int p);
    for (int i = 0; i < 1200 && m_pos != p; i++) step();
    chk("reach_position_timeout", m_pos, p);
  endtask

  task automatic write_cmp(input int v);
    cmp = 9'(v); cmp_vld = 1'b1;
  endtask

  task automatic write_top(input int v);
    top = 9'(v); top_vld = 1'b1;
  endtask

  int hi, pcount;

  initial begin
    rst_n = 1'b0; en = 1'b0; cmp = '0; cmp_vld = 1'b0; top = '0; top_vld = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pwm", pwm, 0);
    chk("reset_ps", ps, 0);
    chk("reset_cmp_act", cmp_act, 0);
    rst_n = 1'b1;

    // Duty 64 of 256.
    write_cmp(64); step();
    en = 1'b1;
    hi = 0; pcount = 0;
    repeat (512) begin
      step();
      hi += int'(pwm); pcount += int'(ps);
      if (ps) chk("s1_ps_with_high", pwm, 1);
    end
    chk("s1_high_count", hi, 128);
    chk("s1_ps_count", pcount, 2);

    // Saturation: 0 and above top.
    write_cmp(0); step(); run_until_pos(0);
    hi = 0; repeat (768) begin step(); hi += int'(pwm); end
    chk("s2_cmp0_highs", hi, 0);
    write_cmp(300); step(); run_until_pos(0);
    hi = 0; repeat (768) begin step(); hi += int'(pwm); end
    chk("s2_cmp300_highs", hi, 768);

    // Mid-period write is deferred to the next period.
    write_cmp(128); step(); run_until_pos(0); run_until_pos(100);
    write_cmp(32);
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      step(); hi += int'(pwm);
      if (m_pos == 0) break;
    end
    chk("s3_tail_highs", hi, 28);
    hi = 0; repeat (256) begin step(); hi += int'(pwm); end
    chk("s3_next_period_highs", hi, 32);

    // Write on the boundary cycle takes effect for the very next period.
    run_until_pos(255);
    write_top(3); write_cmp(2); step();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("s4_pattern", pwm, ((i % 4) < 2) ? 1 : 0);
      chk("s4_ps", ps, ((i % 4) == 0) ? 1 : 0);
    end

    // One-clock period.
    write_top(0); write_cmp(1); step(); run_until_pos(0);
    repeat (6) begin step(); chk("s5_pwm_high", pwm, 1); chk("s5_ps_high", ps, 1); end
    write_cmp(0); step();
    repeat (6) begin step(); chk("s5_pwm_low", pwm, 0); chk("s5_ps_every", ps, 1); end

    // Asynchronous reset mid-period.
    write_top(255); write_cmp(128); step(); run_until_pos(0); run_until_pos(77);
    step();
    chk("s6_pwm_before_reset", pwm, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_async_pwm", pwm, 0);
    chk("s6_async_ps", ps, 0);
    chk("s6_async_cmp_act", cmp_act, 0);
    model_reset();
    step(); step();
    #2 rst_n = 1'b1;
    pcount = 0;
    repeat (512) begin step(); pcount += int'(ps); end
    chk("s6_ps_count_top255", pcount, 2);

    // Randomized traffic with short periods and enable toggling.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) write_cmp(int'($urandom_range(20)));
      if ($urandom_range(9) == 0) write_top(int'($urandom_range(15)));
      if ($urandom_range(39) == 0) en = ~en;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_pwm_modulator

`default_nettype wire
